// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the screen RAM arbiter: grant encoding and default bus widths.
// No logic of its own; pure types and constants.
// Backpressure: not applicable.
package vram_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  typedef logic [1:0] grant_t;

  // Which source owns the RAM port this cycle.
  localparam grant_t GNT_IDLE = 2'd0;
  localparam grant_t GNT_DISP = 2'd1;
  localparam grant_t GNT_HRD  = 2'd2;
  localparam grant_t GNT_HWR  = 2'd3;

endpackage

// File: rtl/vram_wfifo.sv
// Synchronous FIFO holding buffered host writes (packed address+data payload).
// Latency: a pushed entry is visible at the head on the following cycle; head is combinational.
// Backpressure: full blocks pushes and empty blocks pops; simultaneous push/pop is legal at any fill level.
module vram_wfifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               pop_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_dat = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: contents are only observed through valid occupancy.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the single-port screen RAM between display fetches (always first) and host reads/writes.
// Latency: read data valid 2 cycles after the granted request cycle; display fetches fully pipelined.
// Backpressure: host writes stall on a full FIFO (host_wr_ready=0); host reads stall while one is outstanding.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int WFIFO_DEPTH  = 4,
  parameter int STARVE_LIMIT = 800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  input  logic              host_rd_req,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic              host_rd_busy,
  output logic              host_rd_valid,
  output logic [DATA_W-1:0] host_rd_data,
  input  logic              starve_clr,
  output logic              starve_flag,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CW = $clog2(WFIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT);

  grant_t                   grant;
  grant_t                   tag_q;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CW-1:0]            fifo_count;
  logic [ADDR_W+DATA_W-1:0] fifo_head;
  logic [ADDR_W-1:0]        head_addr;
  logic [DATA_W-1:0]        head_data;
  logic                     wr_push;
  logic                     wr_pop;

  logic                     rd_busy_q;
  logic                     rd_issued_q;
  logic [ADDR_W-1:0]        rd_addr_q;
  logic [CW-1:0]            rd_ahead_q;
  logic                     rd_accept;
  logic                     hrd_elig;

  logic [SW-1:0]            starve_cnt_q;
  logic                     host_pending;
  logic                     host_denied;
  logic                     starve_hit;

  assign host_wr_ready = ~fifo_full;
  assign wr_push       = host_wr_valid & host_wr_ready;
  assign wr_pop        = (grant == GNT_HWR);
  assign head_addr     = fifo_head[ADDR_W+DATA_W-1:DATA_W];
  assign head_data     = fifo_head[DATA_W-1:0];

  // A read waits until every write accepted before it has reached the RAM.
  assign rd_accept    = host_rd_req & ~rd_busy_q;
  assign hrd_elig     = rd_busy_q & ~rd_issued_q & (rd_ahead_q == '0);
  assign host_rd_busy = rd_busy_q;

  assign host_pending = ~fifo_empty | hrd_elig;
  assign host_denied  = host_pending & (grant == GNT_DISP);
  assign starve_hit   = host_denied & (starve_cnt_q == SW'(STARVE_LIMIT - 1));

  vram_wfifo #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (WFIFO_DEPTH)
  ) u_wfifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (wr_push),
    .push_dat ({host_wr_addr, host_wr_data}),
    .pop      (wr_pop),
    .pop_dat  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Strict-priority grant: display, then an ordered host read, then buffered writes.
  always_comb begin
    grant = GNT_IDLE;
    if (disp_req)         grant = GNT_DISP;
    else if (hrd_elig)    grant = GNT_HRD;
    else if (!fifo_empty) grant = GNT_HWR;
  end

  // Steer the RAM port from the granted source; only a host write ever raises ram_we.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    case (grant)
      GNT_DISP: ram_addr = disp_addr;
      GNT_HRD:  ram_addr = rd_addr_q;
      GNT_HWR: begin
        ram_addr  = head_addr;
        ram_wdata = head_data;
        ram_we    = 1'b1;
      end
      default: ram_addr = '0;
    endcase
  end

  // Tag pipe: remember who issued the read so returning RAM data is routed to the right owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q         <= GNT_IDLE;
      disp_rvalid   <= 1'b0;
      disp_rdata    <= '0;
      host_rd_valid <= 1'b0;
      host_rd_data  <= '0;
    end else begin
      tag_q         <= grant;
      disp_rvalid   <= (tag_q == GNT_DISP);
      host_rd_valid <= (tag_q == GNT_HRD);
      if (tag_q == GNT_DISP) disp_rdata   <= ram_rdata;
      if (tag_q == GNT_HRD)  host_rd_data <= ram_rdata;
    end
  end

  // Outstanding host read: capture on accept, mark issued on grant, retire with the valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_busy_q   <= 1'b0;
      rd_issued_q <= 1'b0;
      rd_addr_q   <= '0;
    end else if (rd_accept) begin
      rd_busy_q   <= 1'b1;
      rd_issued_q <= 1'b0;
      rd_addr_q   <= host_rd_addr;
    end else begin
      if (grant == GNT_HRD) rd_issued_q <= 1'b1;
      if (host_rd_valid)    rd_busy_q   <= 1'b0;
    end
  end

  // Number of older writes still queued ahead of the outstanding read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ahead_q <= '0;
    end else if (rd_accept) begin
      rd_ahead_q <= fifo_count - CW'(wr_pop);
    end else if (wr_pop && rd_ahead_q != '0) begin
      rd_ahead_q <= rd_ahead_q - 1'b1;
    end
  end

  // Starvation watch: count consecutive cycles the display blocks pending host work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      starve_flag  <= 1'b0;
    end else begin
      if (host_denied) begin
        if (!starve_hit) starve_cnt_q <= starve_cnt_q + 1'b1;
      end else begin
        starve_cnt_q <= '0;
      end
      if (starve_clr)      starve_flag <= 1'b0;
      else if (starve_hit) starve_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        disp_req;
  logic [15:0] disp_addr;
  logic        disp_rvalid;
  logic [7:0]  disp_rdata;
  logic        host_wr_valid;
  logic        host_wr_ready;
  logic [15:0] host_wr_addr;
  logic [7:0]  host_wr_data;
  logic        host_rd_req;
  logic [15:0] host_rd_addr;
  logic        host_rd_busy;
  logic        host_rd_valid;
  logic [7:0]  host_rd_data;
  logic        starve_clr;
  logic        starve_flag;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_dat;
  logic [7:0]  mem [0:65535];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vram_arbiter #(
    .ADDR_W       (16),
    .DATA_W       (8),
    .WFIFO_DEPTH  (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .disp_req      (disp_req),
    .disp_addr     (disp_addr),
    .disp_rvalid   (disp_rvalid),
    .disp_rdata    (disp_rdata),
    .host_wr_valid (host_wr_valid),
    .host_wr_ready (host_wr_ready),
    .host_wr_addr  (host_wr_addr),
    .host_wr_data  (host_wr_data),
    .host_rd_req   (host_rd_req),
    .host_rd_addr  (host_rd_addr),
    .host_rd_busy  (host_rd_busy),
    .host_rd_valid (host_rd_valid),
    .host_rd_data  (host_rd_data),
    .starve_clr    (starve_clr),
    .starve_flag   (starve_flag),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_we        (ram_we),
    .ram_rdata     (ram_rdata)
  );

  // Single-port RAM model with 1-cycle read latency plus a bench preload port.
  always @(posedge clk) begin
    if (pre_we)      mem[pre_addr] <= pre_dat;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    disp_req      = 1'b0;
    disp_addr     = '0;
    host_wr_valid = 1'b0;
    host_wr_addr  = '0;
    host_wr_data  = '0;
    host_rd_req   = 1'b0;
    host_rd_addr  = '0;
    starve_clr    = 1'b0;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_dat  = d;
    next_cycle();
    pre_we   = 1'b0;
  endtask

  task automatic enter_reset();
    rst_n = 1'b0;
    clear_inputs();
    next_cycle();
  endtask

  task automatic leave_reset();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    enter_reset();
    @(negedge clk);
    checks++;
    if ({disp_rvalid, disp_rdata} !== 9'h000) begin
      errors++; $display("FAIL reset_disp: got %b/%h want 0/00", disp_rvalid, disp_rdata);
    end
    checks++;
    if ({host_wr_ready, host_rd_busy, host_rd_valid, starve_flag} !== 4'b1000) begin
      errors++; $display("FAIL reset_flags: got %b want 1000", {host_wr_ready, host_rd_busy, host_rd_valid, starve_flag});
    end
    checks++;
    if ({ram_we, ram_addr, ram_wdata, host_rd_data} !== 33'h0) begin
      errors++; $display("FAIL reset_ram: got we=%b a=%h d=%h rd=%h want all 0", ram_we, ram_addr, ram_wdata, host_rd_data);
    end
    leave_reset();
  endtask

  task automatic test_disp_stream();
    enter_reset();
    for (int i = 0; i < 10; i++) preload(16'(i), 8'(8'h40 + i));
    leave_reset();
    for (int c = 0; c < 14; c++) begin
      disp_req  = (c < 10);
      disp_addr = 16'(c);
      @(negedge clk);
      checks++;
      if (disp_rvalid !== (c >= 2 && c <= 11)) begin
        errors++; $display("FAIL disp_rvalid c%0d: got %b want %b", c, disp_rvalid, (c >= 2 && c <= 11));
      end
      if (c >= 2 && c <= 11) begin
        checks++;
        if (disp_rdata !== 8'(8'h40 + c - 2)) begin
          errors++; $display("FAIL disp_rdata c%0d: got %h want %h", c, disp_rdata, 8'(8'h40 + c - 2));
        end
      end
      checks++;
      if (ram_we !== 1'b0) begin
        errors++; $display("FAIL disp_we c%0d: got %b want 0", c, ram_we);
      end
      next_cycle();
    end
  endtask

  task automatic test_wfifo_full();
    enter_reset();
    leave_reset();
    disp_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      host_wr_valid = 1'b1;
      host_wr_addr  = 16'(16'h0100 + k);
      host_wr_data  = 8'(8'h10 + k);
      @(negedge clk);
      checks++;
      if (host_wr_ready !== (k < 4)) begin
        errors++; $display("FAIL wf_ready k%0d: got %b want %b", k, host_wr_ready, (k < 4));
      end
      next_cycle();
    end
    disp_req = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (j < 2) begin
        checks++;
        if (host_wr_ready !== (j == 1)) begin
          errors++; $display("FAIL wf_ready_drain j%0d: got %b want %b", j, host_wr_ready, (j == 1));
        end
      end
      checks++;
      if (j < 5) begin
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 16'(16'h0100 + j), 8'(8'h10 + j)}) begin
          errors++; $display("FAIL wf_order j%0d: got we=%b a=%h d=%h want 1/%h/%h",
                             j, ram_we, ram_addr, ram_wdata, 16'(16'h0100 + j), 8'(8'h10 + j));
        end
      end else if (ram_we !== 1'b0) begin
        errors++; $display("FAIL wf_idle: got we=%b want 0", ram_we);
      end
      next_cycle();
      if (j == 1) host_wr_valid = 1'b0;
    end
  endtask

  task automatic test_rd_after_wr();
    enter_reset();
    preload(16'h1234, 8'h55);
    leave_reset();
    disp_req = 1'b1; disp_addr = 16'h0010;
    host_wr_valid = 1'b1; host_wr_addr = 16'h1234; host_wr_data = 8'hAA;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      case (c)
        0, 1: begin
          checks++;
          if (ram_we !== 1'b0) begin errors++; $display("FAIL raw_disp_wins c%0d: got %b want 0", c, ram_we); end
        end
        2: begin
          checks++;
          if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 16'h1234, 8'hAA}) begin
            errors++; $display("FAIL raw_write: got %b/%h/%h want 1/1234/aa", ram_we, ram_addr, ram_wdata);
          end
        end
        3: begin
          checks++;
          if ({ram_we, ram_addr} !== {1'b0, 16'h1234}) begin
            errors++; $display("FAIL raw_read: got %b/%h want 0/1234", ram_we, ram_addr);
          end
        end
        default: ;
      endcase
      if (c >= 2) begin
        checks++;
        if (host_rd_busy !== (c <= 5)) begin
          errors++; $display("FAIL raw_busy c%0d: got %b want %b", c, host_rd_busy, (c <= 5));
        end
        checks++;
        if (host_rd_valid !== (c == 5)) begin
          errors++; $display("FAIL raw_valid c%0d: got %b want %b", c, host_rd_valid, (c == 5));
        end
      end
      if (c >= 5) begin
        checks++;
        if (host_rd_data !== 8'hAA) begin
          errors++; $display("FAIL raw_data c%0d: got %h want aa", c, host_rd_data);
        end
      end
      next_cycle();
      if (c == 0) begin host_wr_valid = 1'b0; host_rd_req = 1'b1; host_rd_addr = 16'h1234; end
      if (c == 1) begin disp_req = 1'b0; host_rd_req = 1'b0; end
    end
  endtask

  task automatic test_rd_order();
    logic        exp_we   [6];
    logic [15:0] exp_addr [6];
    exp_we   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_addr = '{16'h0200, 16'h0201, 16'h0300, 16'h0202, 16'h0203, 16'h0000};
    enter_reset();
    preload(16'h0300, 8'h77);
    leave_reset();
    disp_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      host_wr_valid = (c != 2);
      host_wr_addr  = 16'(16'h0200 + (c < 2 ? c : c - 1));
      host_wr_data  = 8'(8'h20 + (c < 2 ? c : c - 1));
      host_rd_req   = (c == 2);
      host_rd_addr  = 16'h0300;
      @(negedge clk);
      checks++;
      if (ram_we !== 1'b0) begin errors++; $display("FAIL ord_held c%0d: got we=%b want 0", c, ram_we); end
      next_cycle();
    end
    host_wr_valid = 1'b0; host_rd_req = 1'b0; disp_req = 1'b0;
    for (int c = 5; c < 11; c++) begin
      @(negedge clk);
      checks++;
      if ({ram_we, ram_addr} !== {exp_we[c-5], exp_addr[c-5]}) begin
        errors++; $display("FAIL ord_seq c%0d: got %b/%h want %b/%h", c, ram_we, ram_addr, exp_we[c-5], exp_addr[c-5]);
      end
      checks++;
      if (host_rd_valid !== (c == 9)) begin
        errors++; $display("FAIL ord_valid c%0d: got %b want %b", c, host_rd_valid, (c == 9));
      end
      if (c == 9) begin
        checks++;
        if (host_rd_data !== 8'h77) begin errors++; $display("FAIL ord_data: got %h want 77", host_rd_data); end
      end
      next_cycle();
    end
  endtask

  task automatic test_starve();
    logic exp;
    enter_reset();
    leave_reset();
    disp_req = 1'b1;
    host_wr_valid = 1'b1; host_wr_addr = 16'h0400; host_wr_data = 8'h44;
    for (int c = 0; c < 17; c++) begin
      starve_clr = (c == 10 || c == 14);
      if (c == 13) disp_req = 1'b0;
      @(negedge clk);
      exp = (c == 9 || c == 10 || c == 12 || c == 13 || c == 14);
      checks++;
      if (starve_flag !== exp) begin
        errors++; $display("FAIL starve c%0d: got %b want %b", c, starve_flag, exp);
      end
      if (c == 13) begin
        checks++;
        if ({ram_we, ram_addr} !== {1'b1, 16'h0400}) begin
          errors++; $display("FAIL starve_drain: got %b/%h want 1/0400", ram_we, ram_addr);
        end
      end
      next_cycle();
      host_wr_valid = 1'b0;
    end
    starve_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    enter_reset();
    leave_reset();
    disp_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      host_wr_valid = (c < 3);
      host_wr_addr  = 16'(16'h0500 + c);
      host_wr_data  = 8'(8'h50 + c);
      host_rd_req   = (c == 3);
      host_rd_addr  = 16'h0500;
      next_cycle();
    end
    host_wr_valid = 1'b0; host_rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (host_rd_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", host_rd_busy); end
    rst_n = 1'b0;
    disp_req = 1'b0;
    #1;
    checks++;
    if ({host_wr_ready, host_rd_busy} !== 2'b10) begin
      errors++; $display("FAIL mid_in_reset: got %b want 10", {host_wr_ready, host_rd_busy});
    end
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({ram_we, host_rd_valid, host_rd_busy, host_wr_ready, disp_rvalid} !== 5'b00010) begin
        errors++; $display("FAIL mid_after c%0d: got we/rv/busy/rdy/dv=%b want 00010", c,
                           {ram_we, host_rd_valid, host_rd_busy, host_wr_ready, disp_rvalid});
      end
      next_cycle();
    end
  endtask

  initial begin
    pre_we   = 1'b0;
    pre_addr = '0;
    pre_dat  = '0;
    rst_n    = 1'b0;
    clear_inputs();
    test_reset();
    test_disp_stream();
    test_wfifo_full();
    test_rd_after_wr();
    test_rd_order();
    test_starve();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
